// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner and single-outstanding instruction fetch sequencer
module pc_fetch_unit #(
    parameter int              N        = 32,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   PCSrc,
    input  logic [N-1:0] PCTarget,
    input  logic [N-1:0] JumpTarget,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic         instr_valid,
    output logic [N-1:0] instr,
    input  logic         instr_ready,
    output logic [N-1:0] PC,
    output logic         align_err,
    output logic [31:0]  fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] pc_sel;
    logic         hold_pc;

    assign imem_addr = PC;
    assign pc_plus4  = PC + N'(4);
    assign hold_pc   = (PCSrc == 2'b11);

    // Raw next-PC candidate chosen by the datapath; alignment is applied at load time.
    always_comb begin
        pc_sel = pc_plus4;
        case (PCSrc)
            2'b00:   pc_sel = pc_plus4;
            2'b01:   pc_sel = PCTarget;
            2'b10:   pc_sel = JumpTarget;
            default: pc_sel = PC;
        endcase
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request strobe; a redirect that lands while a request is in flight
    // must park in S_DROP so the stale response is swallowed.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = ~reset;
                if (redirect_valid) begin
                    state_next = imem_ready ? S_DROP : S_REQ;
                end else if (imem_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // PC, instruction buffer, sticky alignment flag and delivery counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            align_err   <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            PC          <= {redirect_pc[N-1:2], 2'b00};
            align_err   <= align_err | (|redirect_pc[1:0]);
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (!hold_pc) begin
                            PC          <= {pc_sel[N-1:2], 2'b00};
                            align_err   <= align_err | (|pc_sel[1:0]);
                            fetch_count <= fetch_count + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
